// File: rtl/axi4l_pkg.sv
// Shared AXI4-Lite types and constants for the core <-> AXI4-Lite bridges.
package axi4l_pkg;

   // AXI response codes; bit 1 set means the access failed
   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } resp_t;

   // AxPROT encoding
   typedef logic [2:0] prot_t;

   localparam prot_t PROT_DATA  = 3'b000;
   localparam prot_t PROT_INSTR = 3'b100;

   // SLVERR and DECERR are both reported to the core as an error
   function automatic logic resp_is_err(input logic [1:0] resp);
      return (resp == SLVERR) || (resp == DECERR);
   endfunction

endpackage

// File: rtl/core2axi4l.sv
// Ibex-style req/gnt/rvalid memory port to AXI4-Lite master bridge.
// One transaction in flight; the next request can be granted in the
// same cycle that the current response is returned to the core.
module core2axi4l
   import axi4l_pkg::*;
#(
   parameter int    AW   = 32,
   parameter int    DW   = 32,
   parameter prot_t PROT = PROT_DATA
) (
   input  logic            aclk,
   input  logic            areset,
   // core side
   input  logic            core_req,
   output logic            core_gnt,
   input  logic            core_we,
   input  logic [DW/8-1:0] core_be,
   input  logic [AW-1:0]   core_addr,
   input  logic [DW-1:0]   core_wdata,
   output logic            core_rvalid,
   output logic [DW-1:0]   core_rdata,
   output logic            core_err,
   // AXI write address channel
   output logic            awvalid,
   input  logic            awready,
   output logic [AW-1:0]   awaddr,
   output logic [2:0]      awprot,
   // AXI write data channel
   output logic            wvalid,
   input  logic            wready,
   output logic [DW-1:0]   wdata,
   output logic [DW/8-1:0] wstrb,
   // AXI write response channel
   input  logic            bvalid,
   output logic            bready,
   input  logic [1:0]      bresp,
   // AXI read address channel
   output logic            arvalid,
   input  logic            arready,
   output logic [AW-1:0]   araddr,
   output logic [2:0]      arprot,
   // AXI read data channel
   input  logic            rvalid,
   output logic            rready,
   input  logic [DW-1:0]   rdata,
   input  logic [1:0]      rresp
);

   typedef enum logic [2:0] {IDLE, AR, R, AWW, B} state_t;

   // Word-aligned AXI addresses: the byte offset travels in the strobes
   localparam logic [AW-1:0] ADDR_MASK = ~AW'(3);

   state_t          state;
   logic [AW-1:0]   addr_q;
   logic [DW/8-1:0] be_q;
   logic [DW-1:0]   wdata_q;
   logic            we_q;

   logic r_done;
   logic b_done;
   logic resp_done;
   logic aw_done;
   logic w_done;

   assign r_done    = (state == R) && rvalid;
   assign b_done    = (state == B) && bvalid;
   assign resp_done = r_done || b_done;

   // A pending flag counts as done once it has dropped or completes this cycle
   assign aw_done = !awvalid || awready;
   assign w_done  = !wvalid  || wready;

   assign core_gnt    = core_req && ((state == IDLE) || resp_done);
   assign core_rvalid = resp_done;
   assign core_rdata  = (r_done && !we_q) ? rdata : '0;
   assign core_err    = (r_done && resp_is_err(rresp)) || (b_done && resp_is_err(bresp));

   assign awaddr = addr_q;
   assign araddr = addr_q;
   assign wdata  = wdata_q;
   assign wstrb  = be_q;
   assign awprot = PROT;
   assign arprot = PROT;

   // Transaction FSM; all AXI valids/readies are registered here
   // NOTE: the async reset clears every register, including the address/data
   // holding registers, so nothing is left undefined after a mid-txn reset.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state   <= IDLE;
         arvalid <= 1'b0;
         awvalid <= 1'b0;
         wvalid  <= 1'b0;
         rready  <= 1'b0;
         bready  <= 1'b0;
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments only; the accept branch below is
         // placed last so that it overrides the return to IDLE when a new
         // request is granted in the response cycle.
         case (state)
            AR: begin
               if (arready) begin
                  arvalid <= 1'b0;
                  rready  <= 1'b1;
                  state   <= R;
               end
            end
            AWW: begin
               if (awready) awvalid <= 1'b0;
               if (wready)  wvalid  <= 1'b0;
               if (aw_done && w_done) begin
                  bready <= 1'b1;
                  state  <= B;
               end
            end
            R, B: begin
               if (resp_done) begin
                  rready <= 1'b0;
                  bready <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: ;
         endcase

         if (core_gnt) begin
            addr_q  <= core_addr & ADDR_MASK;
            be_q    <= core_be;
            wdata_q <= core_wdata;
            we_q    <= core_we;
            if (core_we) begin
               awvalid <= 1'b1;
               wvalid  <= 1'b1;
               state   <= AWW;
            end else begin
               arvalid <= 1'b1;
               state   <= AR;
            end
         end
      end
   end

   // A response is only ever returned while a transaction is in its response phase
   a_rvalid_owned: assert property (@(posedge aclk) disable iff (areset)
      core_rvalid |-> ((state == R) || (state == B)));

   // A new transaction is only accepted once the previous one has finished
   a_one_outstanding: assert property (@(posedge aclk) disable iff (areset)
      core_gnt |-> ((state == IDLE) || resp_done));

endmodule

// File: tb/tb_core2axi4l.sv
// Randomized self-checking bench for core2axi4l with a transaction-level model
// of the core, the AXI4-Lite slave and the expected bridge behaviour.
module tb_core2axi4l;
   import axi4l_pkg::*;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam logic [2:0] EXP_PROT = 3'b000;

   logic            aclk = 1'b0;
   logic            areset;
   logic            core_req, core_gnt, core_we, core_rvalid, core_err;
   logic [3:0]      core_be;
   logic [31:0]     core_addr, core_wdata, core_rdata;
   logic            awvalid, awready, wvalid, wready, bvalid, bready;
   logic            arvalid, arready, rvalid, rready;
   logic [31:0]     awaddr, araddr, wdata, rdata;
   logic [3:0]      wstrb;
   logic [2:0]      awprot, arprot;
   logic [1:0]      bresp, rresp;

   always #5 aclk = ~aclk;

   core2axi4l #(.AW(AW), .DW(DW), .PROT(PROT_DATA)) dut (
      .aclk(aclk), .areset(areset),
      .core_req(core_req), .core_gnt(core_gnt), .core_we(core_we), .core_be(core_be),
      .core_addr(core_addr), .core_wdata(core_wdata), .core_rvalid(core_rvalid),
      .core_rdata(core_rdata), .core_err(core_err),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
      .bvalid(bvalid), .bready(bready), .bresp(bresp),
      .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
   );

   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      int          gap;
   } req_t;

   // core model
   req_t        plan[$];
   req_t        cur;
   bit          req_on;
   int          gap_cnt;
   // expected bridge state
   bit          busy, m_ar, m_aw, m_w;
   logic [31:0] last_addr, last_wdata;
   logic [3:0]  last_be;
   // slave model
   bit          s_rwait, s_bwait, s_rvalid, s_bvalid;
   int          s_rcnt, s_bcnt;
   logic [31:0] s_rdata;
   logic [1:0]  s_rresp, s_bresp;
   // knobs
   int unsigned ar_pct, aw_pct, w_pct, rdly_min, rdly_max, bdly_max;
   int          ar_block, aw_block, force_resp, lat_exp;
   bit          force_rdata;
   // bookkeeping
   int          cyc, gnt_cyc, checks, failures;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic model_clear();
      busy = 0; m_ar = 0; m_aw = 0; m_w = 0;
      s_rwait = 0; s_bwait = 0; s_rvalid = 0; s_bvalid = 0;
      last_addr = '0; last_wdata = '0; last_be = '0;
      req_on = 0; gap_cnt = -1; lat_exp = 0;
      plan.delete();
   endtask

   task automatic quiet_inputs();
      core_req = 0; core_we = 0; core_be = '0; core_addr = '0; core_wdata = '0;
      awready = 0; wready = 0; arready = 0;
      bvalid = 0; bresp = '0; rvalid = 0; rdata = '0; rresp = '0;
   endtask

   task automatic knobs(input int unsigned ar, input int unsigned aw, input int unsigned w,
                        input int unsigned rmin, input int unsigned rmax, input int unsigned bmax);
      ar_pct = ar; aw_pct = aw; w_pct = w; rdly_min = rmin; rdly_max = rmax; bdly_max = bmax;
   endtask

   task automatic push_req(input bit we, input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] wd, input int gap);
      req_t r;
      r.we = we; r.addr = addr; r.be = be; r.wdata = wd; r.gap = gap;
      plan.push_back(r);
   endtask

   // Sampled mid-cycle: compare DUT against the model, then advance the model
   // by the handshakes that the coming rising edge will complete.
   task automatic observe();
      bit          resp_now, exp_gnt, ar_hs, aw_hs, w_hs;
      logic [31:0] exp_rd;
      logic        exp_err;
      cyc++;
      resp_now = s_rvalid || s_bvalid;
      exp_gnt  = core_req && (!busy || resp_now);
      check("core_gnt",    32'(core_gnt),    32'(exp_gnt));
      check("core_rvalid", 32'(core_rvalid), 32'(resp_now));
      check("arvalid",     32'(arvalid),     32'(m_ar));
      check("awvalid",     32'(awvalid),     32'(m_aw));
      check("wvalid",      32'(wvalid),      32'(m_w));
      check("rready", 32'(rready), 32'(busy && !cur.we && !m_ar));
      check("bready", 32'(bready), 32'(busy && cur.we && !m_aw && !m_w));
      check("araddr", araddr, last_addr & ~32'h3);
      check("awaddr", awaddr, last_addr & ~32'h3);
      check("wdata",  wdata,  last_wdata);
      check("wstrb",  32'(wstrb), 32'(last_be));
      if (m_ar) check("arprot", 32'(arprot), 32'(EXP_PROT));
      if (m_aw) check("awprot", 32'(awprot), 32'(EXP_PROT));
      if (resp_now) begin
         exp_rd  = s_rvalid ? s_rdata : 32'h0;
         exp_err = s_rvalid ? s_rresp[1] : s_bresp[1];
         check("core_rdata", core_rdata, exp_rd);
         check("core_err", 32'(core_err), 32'(exp_err));
         if (lat_exp > 0) check("latency", 32'(cyc - gnt_cyc), 32'(lat_exp));
      end

      ar_hs = m_ar && arready;
      aw_hs = m_aw && awready;
      w_hs  = m_w && wready;
      if (resp_now) begin
         s_rvalid = 0; s_bvalid = 0; busy = 0;
      end
      if (ar_hs) begin
         m_ar = 0; s_rwait = 1; s_rcnt = int'($urandom_range(rdly_min, rdly_max));
      end
      if (aw_hs) m_aw = 0;
      if (w_hs)  m_w  = 0;
      if ((aw_hs || w_hs) && !m_aw && !m_w) begin
         s_bwait = 1; s_bcnt = int'($urandom_range(0, bdly_max));
      end
      if (s_rwait) begin
         if (s_rcnt == 0) begin
            s_rwait  = 0;
            s_rvalid = 1;
            s_rdata  = force_rdata ? 32'hDEAD_BEEF : $urandom;
            s_rresp  = (force_resp >= 0) ? 2'(force_resp) : 2'($urandom_range(0, 3));
         end else s_rcnt--;
      end
      if (s_bwait) begin
         if (s_bcnt == 0) begin
            s_bwait  = 0;
            s_bvalid = 1;
            s_bresp  = (force_resp >= 0) ? 2'(force_resp) : 2'($urandom_range(0, 3));
         end else s_bcnt--;
      end
      if (exp_gnt && plan.size() > 0) begin
         cur        = plan.pop_front();
         busy       = 1;
         req_on     = 0;
         m_ar       = !cur.we;
         m_aw       = cur.we;
         m_w        = cur.we;
         gnt_cyc    = cyc;
         last_addr  = cur.addr;
         last_wdata = cur.wdata;
         last_be    = cur.be;
      end
   endtask

   // Just after the rising edge: drive the slave and core inputs for the next cycle
   task automatic drive();
      arready = (ar_block > 0) ? 1'b0 : ($urandom_range(0, 99) < ar_pct);
      awready = (aw_block > 0) ? 1'b0 : ($urandom_range(0, 99) < aw_pct);
      wready  = ($urandom_range(0, 99) < w_pct);
      if (ar_block > 0) ar_block--;
      if (aw_block > 0) aw_block--;
      rvalid = s_rvalid;
      rdata  = s_rvalid ? s_rdata : $urandom;
      rresp  = s_rvalid ? s_rresp : 2'($urandom);
      bvalid = s_bvalid;
      bresp  = s_bvalid ? s_bresp : 2'($urandom);
      if (!req_on && plan.size() > 0) begin
         if (gap_cnt < 0) gap_cnt = plan[0].gap;
         if (gap_cnt == 0) begin
            req_on = 1; gap_cnt = -1;
         end else gap_cnt--;
      end
      if (req_on) begin
         core_req = 1; core_we = plan[0].we; core_addr = plan[0].addr;
         core_be = plan[0].be; core_wdata = plan[0].wdata;
      end else begin
         core_req = 0; core_we = 1'($urandom); core_addr = $urandom;
         core_be = 4'($urandom); core_wdata = $urandom;
      end
   endtask

   task automatic cycle();
      @(negedge aclk);
      observe();
      @(posedge aclk);
      #1;
      drive();
   endtask

   task automatic run_idle(input int max_cycles);
      int n = 0;
      while ((plan.size() > 0 || busy || req_on) && n < max_cycles) begin
         cycle();
         n++;
      end
      check("drain", 32'((plan.size() > 0) || busy || req_on), 32'(0));
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0; failures = 0; cyc = 0; gnt_cyc = 0;
      ar_block = 0; aw_block = 0; force_resp = -1; force_rdata = 0;
      knobs(100, 100, 100, 0, 0, 0);
      model_clear();
      quiet_inputs();
      areset = 0;
      #1 areset = 1;
      repeat (3) @(posedge aclk);
      #1;
      check("rst_arvalid", 32'(arvalid), 32'(0));
      check("rst_awvalid", 32'(awvalid), 32'(0));
      check("rst_wvalid",  32'(wvalid),  32'(0));
      check("rst_rready",  32'(rready),  32'(0));
      check("rst_bready",  32'(bready),  32'(0));
      check("rst_core_rvalid", 32'(core_rvalid), 32'(0));
      check("rst_araddr", araddr, 32'h0);
      check("rst_wdata",  wdata,  32'h0);
      areset = 0;

      // zero-wait read of 0x1004 returning 0xDEADBEEF, response two cycles after gnt
      force_rdata = 1; force_resp = 0; lat_exp = 2;
      push_req(1'b0, 32'h0000_1004, 4'hF, 32'h0, 0);
      run_idle(50);
      force_rdata = 0; lat_exp = 0;

      // unaligned write: address aligned, strobes and data passed through
      push_req(1'b1, 32'h0000_2003, 4'b0011, 32'h1234_5678, 0);
      run_idle(50);

      // W accepted three cycles before AW, SLVERR response
      force_resp = int'(SLVERR); aw_block = 4;
      push_req(1'b1, 32'h0000_3000, 4'hF, 32'hA5A5_0F0F, 0);
      run_idle(50);
      force_resp = -1;

      // back-to-back read then write with core_req held
      push_req(1'b0, 32'h0000_4008, 4'hF, 32'h0, 0);
      push_req(1'b1, 32'h0000_400C, 4'hC, 32'hCAFE_F00D, 0);
      run_idle(50);

      // AR stalled for over ten cycles while a second request waits
      ar_block = 12;
      push_req(1'b0, 32'h0000_5010, 4'hF, 32'h0, 0);
      push_req(1'b0, 32'h0000_5014, 4'hF, 32'h0, 0);
      run_idle(80);

      // async reset while waiting for R, then a clean read
      knobs(100, 100, 100, 6, 6, 0);
      push_req(1'b0, 32'h0000_6000, 4'hF, 32'h0, 0);
      begin
         int n = 0;
         while (!(busy && !cur.we && !m_ar) && n < 20) begin
            cycle();
            n++;
         end
         check("reach_r", 32'(busy && !cur.we && !m_ar), 32'(1));
      end
      #2 areset = 1;
      #1;
      check("arst_arvalid", 32'(arvalid), 32'(0));
      check("arst_awvalid", 32'(awvalid), 32'(0));
      check("arst_wvalid",  32'(wvalid),  32'(0));
      check("arst_rready",  32'(rready),  32'(0));
      check("arst_bready",  32'(bready),  32'(0));
      check("arst_core_rvalid", 32'(core_rvalid), 32'(0));
      model_clear();
      quiet_inputs();
      @(posedge aclk);
      #1 areset = 0;
      knobs(100, 100, 100, 0, 0, 0);
      push_req(1'b0, 32'h0000_7004, 4'hF, 32'h0, 0);
      run_idle(50);

      // randomized traffic with varying slave back-pressure and response delays
      for (int g = 0; g < 20; g++) begin
         knobs($urandom_range(20, 100), $urandom_range(20, 100), $urandom_range(20, 100),
               0, $urandom_range(0, 3), $urandom_range(0, 3));
         for (int i = 0; i < 10; i++)
            push_req(1'($urandom), $urandom, 4'($urandom), $urandom, int'($urandom_range(0, 2)));
         run_idle(2000);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
